// File: rtl/wave_analyzer_if.sv
// Sample stream into the analyzer and period/amplitude results out of it.
interface wave_analyzer_if #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int PERIOD_WIDTH = 20
);
  logic                           i_sample_valid;
  logic signed [SAMPLE_WIDTH-1:0] i_sample;
  logic [PERIOD_WIDTH-1:0]        o_period;
  logic signed [SAMPLE_WIDTH-1:0] o_max;
  logic signed [SAMPLE_WIDTH-1:0] o_min;
  logic [SAMPLE_WIDTH:0]          o_pp;
  logic                           o_result_valid;
  logic                           o_timeout;

  modport master (
    output i_sample_valid, i_sample,
    input  o_period, o_max, o_min, o_pp, o_result_valid, o_timeout
  );
  modport slave (
    input  i_sample_valid, i_sample,
    output o_period, o_max, o_min, o_pp, o_result_valid, o_timeout
  );
endinterface

// File: rtl/wave_analyzer.sv
// Hysteresis zero-crossing period meter with per-window max/min/peak-to-peak.
module wave_analyzer #(
  parameter int                       SAMPLE_WIDTH = 24,
  parameter int                       PERIOD_WIDTH = 20,
  parameter logic [SAMPLE_WIDTH-1:0]  HYST         = SAMPLE_WIDTH'(4096),
  parameter int unsigned              TIMEOUT      = 2**20-1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  wave_analyzer_if.slave bus
);
  localparam logic signed [SAMPLE_WIDTH-1:0] HYS_P = $signed(HYST);
  localparam logic signed [SAMPLE_WIDTH-1:0] HYS_N = -HYS_P;
  localparam logic [PERIOD_WIDTH-1:0]        TMO   = PERIOD_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {SEEK_LOW, SEEK_HIGH, RUN_HIGH, RUN_LOW} state_e;

  state_e                         state_q, state_d;
  logic [PERIOD_WIDTH-1:0]        cnt_q, cnt_d;
  logic signed [SAMPLE_WIDTH-1:0] max_q, max_d, min_q, min_d;
  logic [PERIOD_WIDTH-1:0]        per_q, per_d;
  logic signed [SAMPLE_WIDTH-1:0] omax_q, omax_d, omin_q, omin_d;
  logic [SAMPLE_WIDTH:0]          pp_q, pp_d;
  logic                           rv_q, rv_d, to_q, to_d;

  logic signed [SAMPLE_WIDTH-1:0] s, wmax, wmin;
  logic [SAMPLE_WIDTH:0]          pp_w;
  logic [PERIOD_WIDTH-1:0]        cnt_inc;
  logic                           vld, is_hi, is_lo, empty, first_rise, rise, tmo;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    min_d   = min_q;
    per_d   = per_q;
    omax_d  = omax_q;
    omin_d  = omin_q;
    pp_d    = pp_q;
    rv_d    = 1'b0;
    to_d    = 1'b0;

    vld   = bus.i_sample_valid;
    s     = bus.i_sample;
    is_hi = s >= HYS_P;
    is_lo = s <= HYS_N;
    // In the seek states cnt is the window's sample count, so zero means no samples yet.
    empty = ((state_q == SEEK_LOW) || (state_q == SEEK_HIGH)) && (cnt_q == '0);
    wmax  = (empty || (s > max_q)) ? s : max_q;
    wmin  = (empty || (s < min_q)) ? s : min_q;
    pp_w  = {wmax[SAMPLE_WIDTH-1], wmax} - {wmin[SAMPLE_WIDTH-1], wmin};
    cnt_inc = cnt_q + PERIOD_WIDTH'(1);

    first_rise = vld && (state_q == SEEK_HIGH) && is_hi;
    rise       = vld && (state_q == RUN_LOW) && is_hi;
    tmo        = vld && !first_rise && !rise && (cnt_inc == TMO);

    if (first_rise || rise) begin
      if (rise) begin
        per_d  = cnt_inc;
        omax_d = wmax;
        omin_d = wmin;
        pp_d   = pp_w;
        rv_d   = 1'b1;
      end
      state_d = RUN_HIGH;
      cnt_d   = '0;
      max_d   = s;
      min_d   = s;
    end else if (tmo) begin
      per_d   = '0;
      omax_d  = wmax;
      omin_d  = wmin;
      pp_d    = pp_w;
      rv_d    = 1'b1;
      to_d    = 1'b1;
      state_d = SEEK_LOW;
      cnt_d   = '0;
    end else if (vld) begin
      cnt_d = cnt_inc;
      max_d = wmax;
      min_d = wmin;
      if (is_lo && (state_q == SEEK_LOW))      state_d = SEEK_HIGH;
      else if (is_lo && (state_q == RUN_HIGH)) state_d = RUN_LOW;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= SEEK_LOW;
      cnt_q   <= '0;
      max_q   <= '0;
      min_q   <= '0;
      per_q   <= '0;
      omax_q  <= '0;
      omin_q  <= '0;
      pp_q    <= '0;
      rv_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      min_q   <= min_d;
      per_q   <= per_d;
      omax_q  <= omax_d;
      omin_q  <= omin_d;
      pp_q    <= pp_d;
      rv_q    <= rv_d;
      to_q    <= to_d;
    end
  end

  assign bus.o_period       = per_q;
  assign bus.o_max          = omax_q;
  assign bus.o_min          = omin_q;
  assign bus.o_pp           = pp_q;
  assign bus.o_result_valid = rv_q;
  assign bus.o_timeout      = to_q;
endmodule

// File: doc/wave_analyzer.md
WAVE_ANALYZER -- requirements
Module: wave_analyzer

Interface
REQ-001 Parameter SAMPLE_WIDTH, 24, signed two's-complement sample width.
REQ-002 Parameter PERIOD_WIDTH, 20, width of the period counter and the o_period output.
REQ-003 Parameter HYST, 24'd4096, crossing hysteresis threshold; the legal range is 1 to 2^(SAMPLE_WIDTH-1)-1.
REQ-004 Parameter TIMEOUT, 2^20-1, maximum measurable period in samples; the legal range is 2 to 2^PERIOD_WIDTH-1.
REQ-005 The block SHALL use a single clock and a synchronous, active-high reset, with the ports named as follows:
- i_clk  in  1  sole clock; all state updates on its rising edge.
- i_rst  in  1  synchronous active-high reset.
REQ-006 The remaining ports SHALL be:
- i_sample_valid  in  1  one-cycle strobe qualifying i_sample; may be held high every cycle or may have gaps.
- i_sample  in  SAMPLE_WIDTH  signed input sample.
- o_period  out  PERIOD_WIDTH  samples between consecutive rising crossings; 0 on timeout.
- o_max  out  SAMPLE_WIDTH  signed maximum over the measured window.
- o_min  out  SAMPLE_WIDTH  signed minimum over the measured window.
- o_pp  out  SAMPLE_WIDTH+1  unsigned peak-to-peak value, equal to o_max - o_min.
- o_result_valid  out  1  one-cycle pulse; the result outputs are updated on the same cycle.
- o_timeout  out  1  one-cycle pulse, coincident with o_result_valid, on a timeout result.

Function
REQ-007 Classification SHALL use signed compares: HI when i_sample >= HYST, LO when i_sample <= -HYST, otherwise MID.
REQ-008 The FSM SHALL have four states: SEEK_LOW, SEEK_HIGH, RUN_HIGH, RUN_LOW; it advances only on cycles with i_sample_valid=1 and holds all state otherwise.
REQ-009 SEEK_LOW: a LO sample SHALL move the FSM to SEEK_HIGH.
REQ-010 SEEK_HIGH: a HI sample is the first rising crossing; the block SHALL set cnt=0 and max=min=sample, enter RUN_HIGH, and produce no result.
REQ-011 RUN_HIGH: each sample SHALL do cnt+1 and update max/min; a LO sample SHALL move the FSM to RUN_LOW.
REQ-012 RUN_LOW: each non-HI sample SHALL do cnt+1 and update max/min.
REQ-013 RUN_LOW, HI sample (rising crossing): the block SHALL publish o_period=cnt+1 and max/min including that sample, then restart with cnt=0 and max=min=sample, and enter RUN_HIGH.
REQ-014 MID samples SHALL never change state.
REQ-015 Timeout: a valid sample in any state that does not cause a rising crossing, where cnt+1 == TIMEOUT, SHALL trigger a timeout.
- The block SHALL publish o_period=0 with max/min of the window including that sample, and pulse o_timeout.
- It SHALL then clear cnt and return to SEEK_LOW.
REQ-016 In the SEEK states, cnt SHALL count valid samples since reset or since the last result; max/min SHALL track those same samples.
REQ-017 Rising crossing and timeout on the same sample: the rising crossing SHALL win, with o_period=TIMEOUT and o_timeout=0.
REQ-018 Latency: o_result_valid and all result outputs SHALL be registered and asserted exactly one i_clk cycle after the completing valid sample.
REQ-019 Between results, o_period/o_max/o_min/o_pp SHALL hold their last published values.
REQ-020 o_pp SHALL be computed at SAMPLE_WIDTH+1 bits without overflow; the full-scale result is 2^SAMPLE_WIDTH-1.
REQ-021 cnt SHALL never exceed TIMEOUT-1 and SHALL never wrap.

Reset
REQ-022 i_rst=1 SHALL force SEEK_LOW, cnt=0, max=min=0, and all outputs to 0, including o_result_valid and o_timeout, on the next edge.
REQ-023 Reset asserted mid-measurement SHALL discard the partial window; the first post-reset result SHALL require a full LO, HI, LO, HI sequence.
REQ-024 A sample presented with i_rst=1 SHALL be ignored.

Verification
REQ-025 Square wave +/-1000000, 8 HI / 8 LO samples, valid every cycle -> every result after the first crossing gives o_period=16, o_max=1000000, o_min=-1000000, o_pp=2000000, with o_result_valid one cycle after the crossing sample.
REQ-026 Same wave with i_sample_valid high one cycle in four -> identical results; the result pulse comes one cycle after each crossing sample.
REQ-027 TIMEOUT=64; samples alternating +4000/-4000 -> no crossing; on the 64th sample o_result_valid=1, o_timeout=1, o_period=0, o_max=4000, o_min=-4000, o_pp=8000.
REQ-028 TIMEOUT=64; rising crossing on the sample where cnt+1=64 -> o_period=64, o_timeout=0.
REQ-029 i_rst pulse after 5 samples of RUN_HIGH -> all outputs 0 next cycle; no result until the full LO, HI, LO, HI sequence is presented.
REQ-030 Square wave +8388607/-8388608, period 10 -> o_pp=16777215, o_period=10.
